// File: rtl/accum_table_wr_seq.sv
// Row-write sequencer: per accepted tile command, waits out the array drain latency and then
// strobes one accumulator-table write per sub-row. Optional stall input under ACCUM_SEQ_STALL_EN.
module accum_table_wr_seq #(
    parameter int unsigned MAX_OUT_ROWS = 128,
    parameter int unsigned MAX_OUT_COLS = 128,
    parameter int unsigned SYS_ARR_ROWS = 16,
    parameter int unsigned SYS_ARR_COLS = 16,
    parameter int unsigned WAIT_W       = 8,
    localparam int unsigned NRS = MAX_OUT_ROWS / SYS_ARR_ROWS,
    localparam int unsigned NCS = MAX_OUT_COLS / SYS_ARR_COLS,
    localparam int unsigned RW  = (NRS > 1) ? $clog2(NRS) : 1,
    localparam int unsigned CW  = (NCS > 1) ? $clog2(NCS) : 1,
    localparam int unsigned SW  = (SYS_ARR_ROWS > 1) ? $clog2(SYS_ARR_ROWS) : 1
) (
    input  logic              clk,
    input  logic              reset,
`ifdef ACCUM_SEQ_STALL_EN
    input  logic              stall,
`endif
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [RW-1:0]     cmd_submat_row_idx,
    input  logic [CW-1:0]     cmd_submat_col_idx,
    input  logic [WAIT_W-1:0] cmd_wait,
    output logic              wr_en_out,
    output logic [SW-1:0]     sub_row,
    output logic [RW-1:0]     submat_row_idx,
    output logic [CW-1:0]     submat_col_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StWait, StEmit} state_e;

    localparam logic [SW-1:0]     LastRow = SW'(SYS_ARR_ROWS - 1);
    localparam logic [WAIT_W-1:0] WaitOne = WAIT_W'(1);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [SW-1:0]       sub_row_q, sub_row_d;
    logic [RW-1:0]       row_q, row_d;
    logic [CW-1:0]       col_q, col_d;
    logic                wr_en_q, wr_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hold;
    logic                last_row;
    logic                accept;

`ifdef ACCUM_SEQ_STALL_EN
    assign hold = stall && (state_q != StIdle);
`else
    assign hold = 1'b0;
`endif

    assign last_row  = (state_q == StEmit) && (sub_row_q == LastRow);
    assign cmd_ready = !reset && !hold && ((state_q == StIdle) || last_row);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        sub_row_d = sub_row_q;
        row_d     = row_q;
        col_d     = col_q;
        done_d    = 1'b0;

        if (!hold) begin
            unique case (state_q)
                StIdle: ;
                StWait: begin
                    if (wait_q == WaitOne) begin
                        state_d   = StEmit;
                        wait_d    = '0;
                        sub_row_d = '0;
                    end else begin
                        wait_d = wait_q - WaitOne;
                    end
                end
                StEmit: begin
                    if (last_row) begin
                        done_d    = 1'b1;
                        state_d   = StIdle;
                        sub_row_d = '0;
                    end else begin
                        sub_row_d = sub_row_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase

            // Accept overrides the last-row return to idle for back-to-back tiles.
            if (accept) begin
                row_d     = cmd_submat_row_idx;
                col_d     = cmd_submat_col_idx;
                sub_row_d = '0;
                if (cmd_wait == '0) begin
                    state_d = StEmit;
                    wait_d  = '0;
                end else begin
                    state_d = StWait;
                    wait_d  = cmd_wait;
                end
            end
        end

        wr_en_d = (state_d == StEmit);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            sub_row_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            sub_row_q <= sub_row_d;
            row_q     <= row_d;
            col_q     <= col_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef ACCUM_SEQ_STALL_EN
    assign wr_en_out = wr_en_q && !hold;
`else
    assign wr_en_out = wr_en_q;
`endif
    assign sub_row        = sub_row_q;
    assign submat_row_idx = row_q;
    assign submat_col_idx = col_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
